lsu_bus_ctrl: RTL

LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

---
 rtl/lsu_bus_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: turns one held core request into a single bus access.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module lsu_bus_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        bus_err,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, bus_err_q, bus_err_d, misalign_q, misalign_d;
    logic [31:0] rdata_q, rdata_d;
    logic        latch_en, stall_c, busy;
    logic        illegal, trap;
    logic [3:0]  be;
    logic [31:0] wdata_rep, load_ext;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign illegal = req_write ? (funct3[2] | (funct3[1:0] == 2'b11))
                               : ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));

`ifdef MISALIGN_TRAP_EN
    assign trap = ~illegal & (((funct3[1:0] == 2'b01) & addr[0]) |
                              ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_v = mem_rdata[7:0];
            2'b01:   byte_v = mem_rdata[15:8];
            2'b10:   byte_v = mem_rdata[23:16];
            default: byte_v = mem_rdata[31:24];
        endcase
        half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{16{half_v[15]}}, half_v};
            3'b100:  load_ext = {24'd0, byte_v};
            3'b101:  load_ext = {16'd0, half_v};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
        misalign_d = 1'b0;
        rdata_d    = rdata_q;
        latch_en   = 1'b0;
        stall_c    = 1'b0;
        mem_req    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    stall_c  = 1'b1;
                    latch_en = 1'b1;
                    if (illegal) begin
                        state_d   = S_DONE;
                        bus_err_d = 1'b1;
                        rdata_d   = 32'd0;
                    end else if (trap) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                        rdata_d    = 32'd0;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = 4'd0;
                    end
                end
            end
            S_BUSY: begin
                stall_c = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = S_DONE;
                    if (!write_q) rdata_d = load_ext;
                // the 15th unacknowledged cycle is the one whose increment would reach 15
                end else if (cnt_q == 4'd14) begin
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            funct3_q   <= 3'd0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= (state_d == S_DONE);
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
            rdata_q    <= rdata_d;
            if (latch_en) begin
                addr_q   <= addr;
                wdata_q  <= wdata;
                funct3_q <= funct3;
                write_q  <= req_write;
            end
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign stall     = stall_c & ~reset;
    assign done      = done_q;
    assign bus_err   = bus_err_q;
    assign misalign  = misalign_q;
    assign rdata     = rdata_q;
    assign mem_we    = busy & write_q;
    assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be    = busy ? be : 4'd0;
    assign mem_wdata = busy ? wdata_rep : 32'd0;

endmodule
